// File: rtl/synthesijer_logic_lshift64_pipe_pkg.sv
// Shared widths and per-stage shift granularities for the 64-bit pipelined left shifter.
package synthesijer_logic_lshift64_pipe_pkg;
  localparam int unsigned WIDTH      = 64;
  localparam int unsigned SHAMT_BITS = 6;
  localparam int unsigned STAGES     = 3;
  localparam int unsigned GRAN_S1    = 16;
  localparam int unsigned GRAN_S2    = 4;
  localparam int unsigned GRAN_S3    = 1;
endpackage

// File: rtl/synthesijer_logic_lshift64_pipe_stage.sv
// One registered shift stage: shifts by GRAN * sel and carries a valid bit.
module synthesijer_lshift_stage
  import synthesijer_logic_lshift64_pipe_pkg::*;
#(
  parameter int unsigned GRAN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       sel,
  input  logic             valid,
  output logic [WIDTH-1:0] shifted,
  output logic             shifted_valid
);

  logic [WIDTH-1:0] shift_c;

  always_comb begin
    shift_c = data;
    case (sel)
      2'd0:    shift_c = data;
      2'd1:    shift_c = data << (GRAN * 1);
      2'd2:    shift_c = data << (GRAN * 2);
      default: shift_c = data << (GRAN * 3);
    endcase
  end

  // Data only advances with a live operation; bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shifted       <= '0;
      shifted_valid <= 1'b0;
    end else begin
      shifted_valid <= valid;
      if (valid) shifted <= shift_c;
    end
  end

endmodule

// File: rtl/synthesijer_logic_lshift64_pipe.sv
// 64-bit logical left shifter, three shift stages plus an output register (latency 3).
module synthesijer_logic_lshift64_pipe
  import synthesijer_logic_lshift64_pipe_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    nd,
  output logic signed [WIDTH-1:0] result,
  output logic                    valid
);

  logic [WIDTH-1:0] s1_data, s2_data, s3_data;
  logic             s1_valid, s2_valid, s3_valid;
  logic [3:0]       s1_rem;
  logic [1:0]       s2_rem;
  logic             unused_bits;

  assign unused_bits = ^b[WIDTH-1:SHAMT_BITS];

  synthesijer_lshift_stage #(.GRAN(GRAN_S1)) u_s1 (
    .clk(clk), .reset(reset), .data(a), .sel(b[5:4]), .valid(nd),
    .shifted(s1_data), .shifted_valid(s1_valid)
  );

  synthesijer_lshift_stage #(.GRAN(GRAN_S2)) u_s2 (
    .clk(clk), .reset(reset), .data(s1_data), .sel(s1_rem[3:2]), .valid(s1_valid),
    .shifted(s2_data), .shifted_valid(s2_valid)
  );

  synthesijer_lshift_stage #(.GRAN(GRAN_S3)) u_s3 (
    .clk(clk), .reset(reset), .data(s2_data), .sel(s2_rem), .valid(s2_valid),
    .shifted(s3_data), .shifted_valid(s3_valid)
  );

  // Remaining shift-amount bits travel alongside the partial data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_rem <= '0;
      s2_rem <= '0;
    end else begin
      if (nd)       s1_rem <= b[3:0];
      if (s1_valid) s2_rem <= s1_rem[1:0];
    end
  end

  // Output register: result holds between valid pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= s3_valid;
      if (s3_valid) result <= s3_data;
    end
  end

endmodule

// File: tb/tb_synthesijer_logic_lshift64_pipe.sv
// Directed and random stimulus against a queue scoreboard of expected results.
module tb_synthesijer_logic_lshift64_pipe;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [63:0] a, b;
  logic               nd;
  logic signed [63:0] result;
  logic               valid;

  typedef struct {
    int          due;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_asserts = 0;
  int          n_fails = 0;
  logic [63:0] last = 64'h0;

  synthesijer_logic_lshift64_pipe dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .nd(nd), .result(result), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Apply one edge of stimulus, then compare outputs against the scoreboard.
  task automatic drive(input logic rst, input logic n, input logic [63:0] av,
                       input logic [63:0] bv, input logic [63:0] e);
    reset = rst;
    nd    = n;
    a     = av;
    b     = bv;
    @(posedge clk);
    if (rst && n) sb.push_back('{due: cyc + 3, val: e});
    if (!rst) begin
      sb.delete();
      last = 64'h0;
    end
    #1;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      last = sb[0].val;
      void'(sb.pop_front());
      check("valid_pulse", 64'(valid), 64'h1);
      check("result", result, last);
    end else begin
      check("valid_idle", 64'(valid), 64'h0);
      check("result_hold", result, last);
    end
    cyc++;
  endtask

  task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic [63:0] e);
    drive(1'b1, 1'b1, av, bv, e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b1, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 64'h5, 64'h0);
  endtask

  initial begin
    logic [63:0] av, bv, e;
    logic        n;

    reset = 1'b0; nd = 1'b0; a = '0; b = '0;
    drive(1'b0, 1'b1, 64'h1, 64'h1, 64'h0);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);

    // Single op, max shift; valid only three edges after issue
    issue(64'h0000_0000_0000_0001, 64'd63, 64'h8000_0000_0000_0000);
    idle(4);

    issue(64'h0123_4567_89AB_CDEF, 64'd4,  64'h1234_5678_9ABC_DEF0);
    issue(64'h0123_4567_89AB_CDEF, 64'd64, 64'h0123_4567_89AB_CDEF);
    idle(4);

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd40, 64'hFFFF_FF00_0000_0000);
    idle(4);

    // Back-to-back issue, then result must hold at 8
    issue(64'h1, 64'd0, 64'h1);
    issue(64'h1, 64'd1, 64'h2);
    issue(64'h1, 64'd2, 64'h4);
    issue(64'h1, 64'd3, 64'h8);
    idle(5);

    // In-flight ops discarded by reset; first op after reset still lands
    issue(64'h7, 64'd2, 64'h1C);
    issue(64'h9, 64'd1, 64'h12);
    drive(1'b0, 1'b1, 64'hF, 64'h1, 64'h0);
    issue(64'h3, 64'h1, 64'h6);
    idle(4);

    for (int i = 0; i < 60; i++) begin
      n  = ($urandom_range(0, 3) != 0);
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      e  = av << bv[5:0];
      drive(1'b1, n, av, bv, e);
    end
    idle(4);

    n_asserts++;
    assert (sb.size() == 0)
    else begin
      n_fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/synthesijer_logic_lshift64_pipe.md
SYNTHESIJER_LOGIC_LSHIFT64_PIPE -- requirements
Module: synthesijer_logic_lshift64_pipe

Interface
REQ-001 SHALL have no parameters; width 64 and latency 3 are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous and active-low (reset=0 resets at a clk rising edge).
REQ-004 a  input  64 (signed)  operand to shift; treated as raw bits.
REQ-005 b  input  64 (signed)  shift amount; only b[5:0] used, b[63:6] ignored.
REQ-006 nd  input  1  new-data strobe; a/b captured on rising edge where nd=1.
REQ-007 result  output  64 (signed)  registered a << b[5:0], zero-filled from LSB.
REQ-008 valid  output  1  one-cycle pulse; result holds the answer for an nd issued 3 edges earlier.

Function
REQ-009 SHALL compute result = a << b[5:0] (logical left shift, zero fill, bits shifted past bit 63 discarded; no saturation, no sign handling).
REQ-010 SHALL implement 3 registered stages:
  - S1: shift by 16*b[5:4]
  - S2: shift by 4*b[3:2]
  - S3: shift by b[1:0]
REQ-011 Each stage SHALL register partial data, remaining shift bits and a valid bit.
REQ-012 Latency SHALL be exactly 3: nd=1 sampled at edge N -> valid=1 and result correct after edge N+3, for one cycle.
REQ-013 Throughput SHALL be one operation per cycle; nd may be high on consecutive edges, with results emerging in issue order on consecutive cycles.
REQ-014 There SHALL be no backpressure or stall; valid pulses are not acknowledged.
REQ-015 nd=0 at an edge SHALL inject a bubble; a and b are don't-care at that edge.
REQ-016 result SHALL update only on edges where the S3 valid bit enters; otherwise it holds its last value.
REQ-017 valid SHALL be 1 for exactly the cycles following edges where a valid operation exits S3, else 0.
REQ-018 b[5:0]=0 SHALL give result=a; b[5:0]=63 SHALL give result = {a[0], 63'b0}.

Reset
REQ-019 On a rising edge with reset=0:
  - all stage valid bits and valid SHALL clear to 0
  - result SHALL clear to 64'h0
  - stage data registers SHALL clear to 0
REQ-020 Operations in flight when reset asserts SHALL be discarded and never produce a valid pulse.
REQ-021 nd sampled while reset=0 SHALL be ignored.
REQ-022 The first nd accepted on the first edge with reset=1 SHALL produce valid 3 edges later.

Structure
REQ-023 A shared package SHALL hold WIDTH=64, SHAMT_BITS=6 and STAGES=3, plus the per-stage shift granularities 16, 4 and 1.
REQ-024 One sub-module synthesijer_lshift_stage SHALL implement one stage, instantiated 3 times:
  - parameter: granularity
  - inputs: data, 2-bit select, valid in
  - outputs: registered data, valid out

Verification
REQ-025 a=64'h0000_0000_0000_0001, b=63, nd pulse at edge 0 -> edge 3: valid=1, result=64'h8000_0000_0000_0000; valid=0 at edges 1, 2 and 4.
REQ-026 a=64'h0123_4567_89AB_CDEF, b=4 -> result=64'h1234_5678_9ABC_DEF0; same a with b=64 (b[5:0]=0) -> result=64'h0123_4567_89AB_CDEF.
REQ-027 a=64'hFFFF_FFFF_FFFF_FFFF, b=-1 (b[5:0]=63) -> result=64'h8000_0000_0000_0000; b=40 -> 64'hFFFF_FF00_0000_0000.
REQ-028 Back-to-back nd at edges 0..3 with b=0,1,2,3 on a=1 -> valid high at edges 3..6 with result=1,2,4,8; result then holds 8 while valid=0.
REQ-029 nd at edges 0 and 1, reset=0 at edge 2 -> valid never pulses, result=0. Next, nd at the first edge with reset=1 (a=3, b=1) -> valid 3 edges later with result=6.
